regfile_stack: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/call_stack.sv | 111 +++++++++++
 rtl/regfile_stack.sv | 74 +++++++
 tb/tb_regfile_stack.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and width helper for the register file / call stack slice.
package regfile_pkg;

    localparam int DEF_DATA_W = 19;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_PC_W   = 8;

    // ceil(log2(v)), minimum 1 so a 1-entry range still gets a real bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address stack: storage, occupancy, full/empty, sticky errors, registered pop output.
module call_stack
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PC_W   = DEF_PC_W,
    parameter int CW     = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PC_W-1:0]   push_data,
    input  logic              pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam int IW = clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DATA_W-1:0]            pop_data_q, pop_data_d;
    logic                         pop_valid_q, pop_valid_d;
    logic                         ovf_q, ovf_d, unf_q, unf_d;
    logic                         ovf_set, unf_set;
    logic [IW-1:0]                wr_idx, top_idx;
    logic [DATA_W-1:0]            push_ext;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_idx   = IW'(count_q);
    assign top_idx  = IW'(count_q - 1'b1);
    assign push_ext = DATA_W'(push_data);

    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    mem_d[wr_idx] = push_ext;
                    count_d       = count_q + 1'b1;
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop_data_d     = mem_q[top_idx];
                    pop_valid_d    = 1'b1;
                    mem_d[top_idx] = '0;
                    count_d        = count_q - 1'b1;
                end
            end
            2'b11: begin
                // simultaneous call/return: swap the top, depth is unchanged
                if (empty) begin
                    unf_set  = 1'b1;
                    mem_d[0] = push_ext;
                    count_d  = CW'(1);
                end else begin
                    pop_data_d     = mem_q[top_idx];
                    pop_valid_d    = 1'b1;
                    mem_d[top_idx] = push_ext;
                end
            end
            default: ;
        endcase
        // a set event in the same cycle beats the clear
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign count     = count_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule

// File: rtl/regfile_stack.sv
// Two-read/one-write register file beside an independent call stack.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_stack
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PC_W   = DEF_PC_W,
    parameter int AW     = clog2(NREGS),
    parameter int CW     = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              push,
    input  logic [PC_W-1:0]   push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [CW-1:0]     stack_count,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf_err,
    output logic              unf_err,
    input  logic              err_clr
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
    assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
`else
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
`endif

    call_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .CW     (CW)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .err_clr   (err_clr),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

endmodule

// File: tb/tb_regfile_stack.sv
// Directed self-checking bench for regfile_stack (default parameters).
module tb_regfile_stack;

    logic        clk, reset, we, push, pop, err_clr;
    logic [2:0]  waddr, raddr1, raddr2;
    logic [18:0] wdata, rdata1, rdata2, pop_data;
    logic [7:0]  push_data;
    logic        pop_valid, stack_full, stack_empty, ovf_err, unf_err;
    logic [3:0]  stack_count;

    int checks = 0;
    int errors = 0;

    regfile_stack dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .push(push), .push_data(push_data), .pop(pop), .pop_data(pop_data),
        .pop_valid(pop_valid), .stack_count(stack_count), .stack_full(stack_full),
        .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; we = 0; push = 0; pop = 0; err_clr = 0;
        waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0; push_data = 0;
        #12;
        chk("rst_count", stack_count, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_popv", pop_valid, 0);
        chk("rst_popd", pop_data, 0);
        chk("rst_errs", {ovf_err, unf_err}, 0);
        chk("rst_rd1", rdata1, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // register write then read
        we = 1; waddr = 3; wdata = 19'h1ABCD;
        tick();
        we = 0; raddr1 = 3; raddr2 = 0;
        #1;
        chk("rd1_r3", rdata1, 19'h1ABCD);
        chk("rd2_r0", rdata2, 0);

        // same-cycle write/read
        we = 1; waddr = 5; wdata = 7; raddr1 = 5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r5", rdata1, 7);
`else
        chk("nobypass_r5", rdata1, 0);
`endif
        tick();
        we = 0;
        #1;
        chk("after_wr_r5", rdata1, 7);
        raddr1 = 3;

        // fill the stack
        for (int i = 0; i < 8; i++) begin
            push = 1; push_data = 8'h10 + 8'(i);
            tick();
        end
        chk("fill_count", stack_count, 8);
        chk("fill_full", stack_full, 1);
        chk("fill_empty", stack_empty, 0);
        chk("fill_ovf0", ovf_err, 0);
        push_data = 8'hFF;
        tick();
        chk("ovf_set", ovf_err, 1);
        chk("ovf_count", stack_count, 8);
        push = 0; pop = 1;
        tick();
        pop = 0;
        chk("pop_top", pop_data, 19'h17);
        chk("pop_pulse", pop_valid, 1);
        chk("pop_count", stack_count, 7);
        chk("ovf_sticky", ovf_err, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("pop_pulse_end", pop_valid, 0);
        chk("pop_hold", pop_data, 19'h17);
        chk("ovf_clr", ovf_err, 0);
        chk("regs_intact", rdata1, 19'h1ABCD);

        // drain; last value must be the first pushed, and not 8'hFF
        pop = 1;
        for (int i = 0; i < 7; i++) tick();
        pop = 0;
        chk("drain_last", pop_data, 19'h10);
        chk("drain_empty", stack_empty, 1);

        // underflow
        pop = 1;
        tick();
        pop = 0;
        chk("unf_set", unf_err, 1);
        chk("unf_popv", pop_valid, 0);
        chk("unf_hold", pop_data, 19'h10);
        chk("unf_count", stack_count, 0);
        err_clr = 1;
        tick();
        chk("unf_clr", unf_err, 0);
        pop = 1;
        tick();
        pop = 0;
        chk("unf_set_wins", unf_err, 1);
        tick();
        err_clr = 0;
        chk("unf_clr2", unf_err, 0);

        // push+pop on non-empty stack
        push = 1; push_data = 8'h22;
        tick();
        push_data = 8'h33; pop = 1;
        tick();
        push = 0;
        chk("swap_popd", pop_data, 19'h22);
        chk("swap_count", stack_count, 1);
        chk("swap_popv", pop_valid, 1);
        chk("swap_unf", unf_err, 0);
        tick();
        pop = 0;
        chk("swap_next", pop_data, 19'h33);
        chk("swap_empty", stack_empty, 1);

        // push+pop while empty
        push = 1; pop = 1; push_data = 8'h44;
        tick();
        push = 0;
        chk("pp_empty_count", stack_count, 1);
        chk("pp_empty_unf", unf_err, 1);
        chk("pp_empty_popv", pop_valid, 0);
        tick();
        pop = 0;
        chk("pp_empty_val", pop_data, 19'h44);
        err_clr = 1;
        tick();
        err_clr = 0;

        // reset in the middle of a push sequence
        push = 1;
        for (int i = 0; i < 4; i++) begin
            push_data = 8'h50 + 8'(i);
            tick();
        end
        chk("pre_rst_count", stack_count, 4);
        #2;
        reset = 1;
        #1;
        chk("arst_count", stack_count, 0);
        chk("arst_popd", pop_data, 0);
        chk("arst_empty", stack_empty, 1);
        chk("arst_rd1", rdata1, 0);
        chk("arst_errs", {ovf_err, unf_err, pop_valid}, 0);
        tick();
        reset = 0; push = 0;
        #1;
        chk("rel_empty", stack_empty, 1);
        chk("rel_full", stack_full, 0);
        pop = 1;
        tick();
        pop = 0;
        chk("rel_unf", unf_err, 1);
        chk("rel_popv", pop_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
